filter_out_framer: RTL

Downstream stage of the adaptive filter core. It accepts the core's filtered 16-bit samples over a ready/valid stream and buffers them in a small FIFO. It packs them into fixed-length frames: sync word, sequence word, payload, checksum. Frames leave on a registered ready/valid output toward the host link. A flush request closes a partial frame by zero-padding it.

---
 rtl/filter_out_framer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/filter_out_framer.sv
// Packs filtered samples from a small input FIFO into frames of
// sync word, sequence word, FRAME_LEN payload words and a wrap-around checksum.
module filter_out_framer #(
    parameter int          DATA_WIDTH = 16,
    parameter int          FRAME_LEN  = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] SYNC_WORD  = 16'hA5C3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [15:0]                  m_data,
    output logic                         m_last,
    input  logic                         flush,
    output logic [15:0]                  frame_count,
    output logic                         busy
);

    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [7:0] FL8      = 8'(FRAME_LEN);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR     = 3'd1;
    localparam logic [2:0] ST_SEQ     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_CSUM    = 3'd4;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_count;
    logic [2:0]            r_state;
    logic [7:0]            r_seq;
    logic [7:0]            r_pcnt;
    logic [15:0]           r_csum;
    logic                  r_flush_pend;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_load_en;
    logic        w_have_pay;
    logic [15:0] w_pay_data;
    logic        w_word_valid;
    logic [15:0] w_word;
    logic        w_word_last;
    logic        w_hdr;
    logic        w_pay;
    logic [2:0]  w_next_state;
    logic        w_csum_done;
    logic        w_idle_clear;

    assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign s_ready     = !w_full;
    assign w_push      = s_valid && !w_full;
    assign w_load_en   = !m_valid || m_ready;
    assign w_have_pay  = !w_empty || r_flush_pend;
    assign w_pay_data  = w_empty ? 16'h0000 : 16'(r_mem[r_rptr]);
    assign w_csum_done = (r_state == ST_CSUM) && m_valid && m_ready;
    assign w_idle_clear = (r_state == ST_IDLE) && w_empty && r_flush_pend;
    assign busy        = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The state names the word currently held in the output register;
    // a new word is chosen only when that register is free to load.
    always_comb begin
        w_word_valid = 1'b0;
        w_word       = 16'h0000;
        w_word_last  = 1'b0;
        w_pop        = 1'b0;
        w_hdr        = 1'b0;
        w_pay        = 1'b0;
        w_next_state = r_state;
        if (w_load_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_word_valid = 1'b1;
                        w_word       = SYNC_WORD;
                        w_hdr        = 1'b1;
                        w_next_state = ST_HDR;
                    end
                end
                ST_HDR: begin
                    w_word_valid = 1'b1;
                    w_word       = {FL8, r_seq};
                    w_next_state = ST_SEQ;
                end
                ST_SEQ, ST_PAYLOAD: begin
                    if (r_state == ST_PAYLOAD && r_pcnt == FL8) begin
                        w_word_valid = 1'b1;
                        w_word       = r_csum;
                        w_word_last  = 1'b1;
                        w_next_state = ST_CSUM;
                    end else if (w_have_pay) begin
                        w_word_valid = 1'b1;
                        w_word       = w_pay_data;
                        w_pop        = !w_empty;
                        w_pay        = 1'b1;
                        w_next_state = ST_PAYLOAD;
                    end
                end
                ST_CSUM: begin
                    w_next_state = ST_IDLE;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            m_valid      <= 1'b0;
            m_data       <= 16'h0000;
            m_last       <= 1'b0;
            r_seq        <= 8'd0;
            r_pcnt       <= 8'd0;
            r_csum       <= 16'h0000;
            frame_count  <= 16'h0000;
            r_flush_pend <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load_en) begin
                m_valid <= w_word_valid;
                if (w_word_valid) begin
                    m_data <= w_word;
                    m_last <= w_word_last;
                end else begin
                    m_last <= 1'b0;
                end
            end
            if (w_hdr) begin
                r_pcnt <= 8'd0;
                r_csum <= 16'h0000;
            end else if (w_pay) begin
                r_pcnt <= r_pcnt + 8'd1;
                r_csum <= r_csum + w_pay_data;
            end
            if (w_csum_done) begin
                frame_count <= frame_count + 16'd1;
                r_seq       <= r_seq + 8'd1;
            end
            // A fresh flush request wins over the end-of-frame clear.
            if (flush) begin
                r_flush_pend <= 1'b1;
            end else if (w_csum_done || w_idle_clear) begin
                r_flush_pend <= 1'b0;
            end
        end
    end

endmodule
